// File: rtl/cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : cordic_phase_gen
// Description : Burst phase generator that feeds a CORDIC rotator. It stores
//               a configuration (frequency, start phase, amplitude, count) and
//               on each start request issues count samples with z_i stepping
//               by freq. It supports stall (hold) and early termination
//               (abort).
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_gen #(
    parameter int XY_BITS  = 12,
    parameter int PH_BITS  = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PH_BITS-1:0]  cfg_freq,
    input  logic [PH_BITS-1:0]  cfg_phase0,
    input  logic [XY_BITS-1:0]  cfg_amp,
    input  logic [CNT_BITS-1:0] cfg_count,
    input  logic                start,
    input  logic                hold,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                ivalid,
    output logic [XY_BITS-1:0]  x_i,
    output logic [XY_BITS-1:0]  y_i,
    output logic [PH_BITS-1:0]  z_i
);

    localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [PH_BITS-1:0]  r_freq;
    logic [PH_BITS-1:0]  r_phase0;
    logic [XY_BITS-1:0]  r_amp;
    logic [CNT_BITS-1:0] r_count;
    logic [PH_BITS-1:0]  r_phase_acc;
    logic [CNT_BITS-1:0] r_remaining;
    logic                r_ivalid;
    logic                r_done;
    logic [XY_BITS-1:0]  r_x;
    logic [XY_BITS-1:0]  r_y;
    logic [PH_BITS-1:0]  r_z;

    logic                w_cfg_accept;
    logic                w_start_ok;
    logic                w_issue;
    logic                w_last;

    // Handshake and burst-control qualifiers; a config offer always wins
    // over a start in the same cycle, and an empty stored count never starts.
    always_comb begin
        cfg_ready    = (r_state == ST_IDLE) && reset;
        w_cfg_accept = cfg_valid && cfg_ready;
        w_start_ok   = (r_state == ST_IDLE) && start && !cfg_valid &&
                       (r_count != '0);
        w_issue      = (r_state == ST_RUN) && !abort && !hold;
        w_last       = w_issue && (r_remaining == c_cnt_one);
        busy         = (r_state == ST_RUN);
        done         = r_done;
        ivalid       = r_ivalid;
        x_i          = r_x;
        y_i          = r_y;
        z_i          = r_z;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks both hold and end-of-burst.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Configuration storage, phase accumulator and registered CORDIC operands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_freq      <= '0;
            r_phase0    <= '0;
            r_amp       <= '0;
            r_count     <= '0;
            r_phase_acc <= '0;
            r_remaining <= '0;
            r_ivalid    <= 1'b0;
            r_done      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
        end else begin
            r_done <= (r_state == ST_DONE);

            if (w_cfg_accept) begin
                r_freq   <= cfg_freq;
                r_phase0 <= cfg_phase0;
                r_amp    <= cfg_amp;
                r_count  <= cfg_count;
            end

            case (r_state)
                ST_IDLE: begin
                    r_ivalid <= 1'b0;
                    if (w_start_ok) begin
                        r_phase_acc <= r_phase0;
                        r_remaining <= r_count;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_ivalid    <= 1'b0;
                        r_phase_acc <= '0;
                        r_remaining <= '0;
                    end else if (hold) begin
                        // Stall: operands keep their last values.
                        r_ivalid <= 1'b0;
                    end else begin
                        r_ivalid    <= 1'b1;
                        r_x         <= r_amp;
                        r_y         <= '0;
                        r_z         <= r_phase_acc;
                        // Modular phase step; carry out is intentionally lost.
                        r_phase_acc <= r_phase_acc + r_freq;
                        r_remaining <= r_remaining - c_cnt_one;
                    end
                end
                default: begin
                    r_ivalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_phase_gen
// Description : Self-checking bench for cordic_phase_gen: table vectors,
//               directed corner sequences and randomized bursts checked
//               against an arithmetic phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_freq = '0;
    logic [31:0] cfg_phase0 = '0;
    logic [11:0] cfg_amp = '0;
    logic [15:0] cfg_count = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        ivalid;
    logic [11:0] x_i;
    logic [11:0] y_i;
    logic [31:0] z_i;

    int n_checks = 0;
    int n_errors = 0;

    cordic_phase_gen #(.XY_BITS(12), .PH_BITS(32), .CNT_BITS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_freq   (cfg_freq),
        .cfg_phase0 (cfg_phase0),
        .cfg_amp    (cfg_amp),
        .cfg_count  (cfg_count),
        .start      (start),
        .hold       (hold),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ivalid     (ivalid),
        .x_i        (x_i),
        .y_i        (y_i),
        .z_i        (z_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      freq;
        logic [31:0]      ph0;
        logic [11:0]      amp;
        int               cnt;
        logic [7:0]       mask;
        logic [3:0][31:0] exp_z;
        int               ntab;
        int               span;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic configure(input logic [31:0] f, input logic [31:0] p,
                             input logic [11:0] a, input logic [15:0] c);
        chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
        cfg_valid  = 1'b1;
        cfg_freq   = f;
        cfg_phase0 = p;
        cfg_amp    = a;
        cfg_count  = c;
        tick;
        cfg_valid  = 1'b0;
    endtask

    // Model: sample k carries z = ph0 + k*freq (mod 2^32), x = amp, y = 0;
    // done follows the last sample by one cycle; z holds during stalls.
    task automatic burst(input logic [31:0] freq, input logic [31:0] ph0,
                         input logic [11:0] amp, input int cnt,
                         input logic [7:0] mask, input bit rnd_hold, input bit noise,
                         input logic [3:0][31:0] tab, input int ntab,
                         output int n_iv, output int span);
        int          k;
        int          first;
        int          last;
        bit          got_done;
        logic [31:0] exp_z;
        logic [31:0] prev_z;
        k = 0; first = -1; last = -1; got_done = 1'b0; prev_z = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ivalid_after_start", 64'(ivalid), 64'd0);
        for (int i = 1; i <= cnt * 8 + 20; i++) begin
            if (rnd_hold) hold = ($urandom_range(0, 2) == 0);
            else          hold = (i <= 8) ? mask[i-1] : 1'b0;
            if (busy) chk("cfg_ready_run", 64'(cfg_ready), 64'd0);
            if (noise && busy) begin
                cfg_valid  = 1'($urandom_range(0, 1));
                cfg_freq   = $urandom;
                cfg_phase0 = $urandom;
                cfg_count  = 16'($urandom);
                start      = 1'($urandom_range(0, 1));
            end
            tick;
            cfg_valid = 1'b0;
            start     = 1'b0;
            hold      = 1'b0;
            if (ivalid) begin
                exp_z = ph0 + freq * 32'(k);
                chk("z_i", 64'(z_i), 64'(exp_z));
                if (k < ntab) chk("z_i_table", 64'(z_i), 64'(tab[k]));
                chk("x_i", 64'(x_i), 64'(amp));
                chk("y_i", 64'(y_i), 64'd0);
                if (first < 0) first = i;
                last   = i;
                prev_z = exp_z;
                k++;
            end else if (busy && k > 0) begin
                chk("z_i_held", 64'(z_i), 64'(prev_z));
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_ivalid", 64'(ivalid), 64'd0);
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_cfg_ready", 64'(cfg_ready), 64'd1);
                chk("done_sample_count", 64'(k), 64'(cnt));
                chk("done_latency", 64'(i), 64'(last + 1));
                tick;
                chk("done_one_cycle", 64'(done), 64'd0);
                break;
            end
        end
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        n_iv = k;
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick;
            chk({name, "_ivalid"}, 64'(ivalid), 64'd0);
            chk({name, "_done"}, 64'(done), 64'd0);
            chk({name, "_busy"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n_iv;
        int               span;
        logic [3:0][31:0] no_tab;
        logic [31:0]      f;
        logic [31:0]      p;
        logic [11:0]      a;
        int               c;
        no_tab = '0;

        vt[0] = '{32'h40000000, 32'h0, 12'h7FF, 4, 8'h00,
                  {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000}, 4, 4};
        vt[1] = '{32'h80000000, 32'hC0000000, 12'h123, 3, 8'h00,
                  {32'h00000000, 32'hC0000000, 32'h40000000, 32'hC0000000}, 3, 3};
        vt[2] = '{32'h01000000, 32'h00000010, 12'h400, 5, 8'h06,
                  {32'h03000010, 32'h02000010, 32'h01000010, 32'h00000010}, 4, 7};
        vt[3] = '{32'h00000005, 32'hFFFFFFFF, 12'hFFF, 1, 8'h00,
                  {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 1, 1};

        // Reset state
        tick;
        tick;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_ivalid", 64'(ivalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_x", 64'(x_i), 64'd0);
        chk("rst_y", 64'(y_i), 64'd0);
        chk("rst_z", 64'(z_i), 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_cnt0_after_reset", 64'(busy), 64'd0);
        quiet("cnt0_after_reset", 2);

        // Table-driven bursts
        for (int v = 0; v < 4; v++) begin
            configure(vt[v].freq, vt[v].ph0, vt[v].amp, 16'(vt[v].cnt));
            burst(vt[v].freq, vt[v].ph0, vt[v].amp, vt[v].cnt, vt[v].mask, 1'b0, 1'b0,
                  vt[v].exp_z, vt[v].ntab, n_iv, span);
            chk("tab_ivalid_count", 64'(n_iv), 64'(vt[v].cnt));
            chk("tab_ivalid_span", 64'(span), 64'(vt[v].span));
        end

        // Abort after the second sample, together with hold; then restart
        configure(32'h100, 32'h1000, 12'h055, 16'd10);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("abort_s0_z", 64'(z_i), 64'h1000);
        tick;
        chk("abort_s1_z", 64'(z_i), 64'h1100);
        abort = 1'b1;
        hold  = 1'b1;
        tick;
        abort = 1'b0;
        hold  = 1'b0;
        chk("abort_ivalid", 64'(ivalid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_cfg_ready", 64'(cfg_ready), 64'd1);
        quiet("after_abort", 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_idle_cfg_ready", 64'(cfg_ready), 64'd1);
        burst(32'h100, 32'h1000, 12'h055, 10, 8'h00, 1'b0, 1'b0, no_tab, 0, n_iv, span);
        chk("restart_count", 64'(n_iv), 64'd10);

        // cfg_valid with start in the same IDLE cycle: config taken, start ignored
        cfg_valid  = 1'b1;
        cfg_freq   = 32'h3;
        cfg_phase0 = 32'h7;
        cfg_amp    = 12'h011;
        cfg_count  = 16'd6;
        start      = 1'b1;
        tick;
        cfg_valid  = 1'b0;
        start      = 1'b0;
        chk("cfg_start_busy", 64'(busy), 64'd0);
        quiet("cfg_start", 3);
        burst(32'h3, 32'h7, 12'h011, 6, 8'h00, 1'b0, 1'b0, no_tab, 0, n_iv, span);
        chk("stored_cfg_count", 64'(n_iv), 64'd6);

        // Start with a stored count of zero
        configure(32'h1, 32'h2, 12'h003, 16'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("cnt0_busy", 64'(busy), 64'd0);
        quiet("cnt0", 3);

        // Reset mid-burst
        configure(32'h10, 32'h20, 12'h030, 16'd8);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("midrst_ivalid", 64'(ivalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_x", 64'(x_i), 64'd0);
        chk("midrst_z", 64'(z_i), 64'd0);
        chk("midrst_cfg_ready", 64'(cfg_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(cfg_ready), 64'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("midrst_start_ignored", 64'(busy), 64'd0);
        quiet("midrst", 3);

        // Randomized bursts with random stalls and ignored traffic in RUN;
        // even iterations replay the stored config to confirm it persists.
        for (int r = 0; r < 20; r++) begin
            f = $urandom;
            p = $urandom;
            a = 12'($urandom_range(0, 4095));
            c = $urandom_range(1, 20);
            configure(f, p, a, 16'(c));
            burst(f, p, a, c, 8'h00, 1'b1, 1'b1, no_tab, 0, n_iv, span);
            if ((r % 2) == 0)
                burst(f, p, a, c, 8'h00, 1'b1, 1'b1, no_tab, 0, n_iv, span);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
